// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-requester memory arbiter: default widths,
// requester identifiers and the supported read-latency range.
package mem_arb_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int ADDR_W_DEF = 3;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int MEM_RD_LAT_MIN = 1;
  localparam int MEM_RD_LAT_MAX = 4;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational two-way grant: a lone valid always wins, and when both sides
// are valid the pointer decides.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic ptr,
  output logic grant0,
  output logic grant1
);

  // Grant decode from the two valids and the priority pointer
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (valid0 && valid1) begin
      if (ptr == REQ0) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else if (valid0) begin
      grant0 = 1'b1;
    end else if (valid1) begin
      grant1 = 1'b1;
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port register memory.
// Define MEM_ARB_FIXED_PRIO_EN for fixed requester-0 priority (no pointer).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              RESET_L,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  output logic              rd0_valid,
  output logic [DATA_W-1:0] rd0_data,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rd1_valid,
  output logic [DATA_W-1:0] rd1_data,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in
);

  logic                  grant0_s;
  logic                  grant1_s;
  logic                  any_grant_s;
  logic                  ptr_s;
  logic                  sel_write_s;
  logic [ADDR_W-1:0]     sel_addr_s;
  logic [DATA_W-1:0]     sel_data_s;
  logic                  rd_tag_r;
  logic [MEM_RD_LAT-1:0] pipe_vld_r;
  logic [MEM_RD_LAT-1:0] pipe_tag_r;
  logic                  exit_vld_s;
  logic                  exit_tag_s;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign ptr_s = REQ0;
`else
  logic ptr_r;

  // Priority pointer: after a grant it names the side that was not served
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      ptr_r <= REQ0;
    end else if (any_grant_s) begin
      ptr_r <= grant0_s ? REQ1 : REQ0;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr_s = ptr_r;
`endif

  mem_arb_rr_pick u_pick (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .ptr    (ptr_s),
    .grant0 (grant0_s),
    .grant1 (grant1_s)
  );

  assign req0_ready  = grant0_s;
  assign req1_ready  = grant1_s;
  assign any_grant_s = grant0_s | grant1_s;

  // Steer the granted requester's command fields toward the memory registers
  always_comb begin
    sel_write_s = req0_write;
    sel_addr_s  = req0_addr;
    sel_data_s  = req0_data;
    if (grant1_s) begin
      sel_write_s = req1_write;
      sel_addr_s  = req1_addr;
      sel_data_s  = req1_data;
    end else begin
      sel_write_s = req0_write;
      sel_addr_s  = req0_addr;
      sel_data_s  = req0_data;
    end
  end

  // Memory command registers; address and write data hold while idle
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      mem_write    <= 1'b0;
      mem_read     <= 1'b0;
      mem_address  <= {ADDR_W{1'b0}};
      mem_data_out <= {DATA_W{1'b0}};
      rd_tag_r     <= REQ0;
    end else begin
      mem_write <= any_grant_s & sel_write_s;
      mem_read  <= any_grant_s & ~sel_write_s;
      if (any_grant_s) begin
        mem_address <= sel_addr_s;
        rd_tag_r    <= grant1_s;
      end
      if (any_grant_s && sel_write_s) begin
        mem_data_out <= sel_data_s;
      end
    end
  end

  // Read-tag pipeline tracking which requester owns each returning word
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      pipe_vld_r <= {MEM_RD_LAT{1'b0}};
      pipe_tag_r <= {MEM_RD_LAT{1'b0}};
    end else begin
      pipe_vld_r[0] <= mem_read;
      pipe_tag_r[0] <= rd_tag_r;
      for (int i = 1; i < MEM_RD_LAT; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        pipe_tag_r[i] <= pipe_tag_r[i-1];
      end
    end
  end

  assign exit_vld_s = pipe_vld_r[MEM_RD_LAT-1];
  assign exit_tag_s = pipe_tag_r[MEM_RD_LAT-1];

  // Read return registers; the non-owning side keeps its previous data
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      rd0_valid <= 1'b0;
      rd1_valid <= 1'b0;
      rd0_data  <= {DATA_W{1'b0}};
      rd1_data  <= {DATA_W{1'b0}};
    end else begin
      rd0_valid <= exit_vld_s & (exit_tag_s == REQ0);
      rd1_valid <= exit_vld_s & (exit_tag_s == REQ1);
      if (exit_vld_s && (exit_tag_s == REQ0)) begin
        rd0_data <= mem_data_in;
      end
      if (exit_vld_s && (exit_tag_s == REQ1)) begin
        rd1_data <= mem_data_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus hand sequences,
// with a behavioural memory and a read-return scoreboard queue.
module tb_mem_arbiter;

  localparam int DW  = 6;
  localparam int AW  = 3;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          RESET_L;
  logic          req0_valid, req0_write, req0_ready, rd0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data, rd0_data;
  logic          req1_valid, req1_write, req1_ready, rd1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data, rd1_data;
  logic          mem_write, mem_read;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_out, mem_data_in;

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_RD_LAT(LAT)) dut (
    .clk(clk), .RESET_L(RESET_L),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_ready(req0_ready), .rd0_valid(rd0_valid),
    .rd0_data(rd0_data),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_ready(req1_ready), .rd1_valid(rd1_valid),
    .rd1_data(rd1_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
  );

  always #5 clk = ~clk;

  // Behavioural 8x6 memory with LAT-cycle registered read data
  logic [DW-1:0] mem_model [8];
  logic [DW-1:0] rd_pipe [LAT];
  initial begin
    for (int i = 0; i < 8; i++) mem_model[i] = 6'd0;
    for (int i = 0; i < LAT; i++) rd_pipe[i] = 6'd0;
  end
  always @(posedge clk) begin
    if (mem_write) mem_model[mem_address] <= mem_data_out;
    if (mem_read) rd_pipe[0] <= mem_model[mem_address];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_data_in = rd_pipe[LAT-1];

  typedef struct {
    logic v0; logic w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic v1; logic w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic g0; logic g1;
  } vec_t;

  typedef struct {
    logic          tag;
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;

  vec_t          vt[$];
  rd_exp_t       rdq[$];
  logic [DW-1:0] shadow [8];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  logic          exp_mw, exp_mr;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_dout, exp_rd0, exp_rd1;

  function automatic vec_t mk(input logic v0, input logic w0, input logic [AW-1:0] a0,
                              input logic [DW-1:0] d0, input logic v1, input logic w1,
                              input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic g0, input logic g1);
    vec_t v;
    v.v0 = v0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero();
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_address", {29'd0, mem_address}, 32'd0);
    chk("rst_mem_data_out", {26'd0, mem_data_out}, 32'd0);
    chk("rst_rd0_valid", {31'd0, rd0_valid}, 32'd0);
    chk("rst_rd1_valid", {31'd0, rd1_valid}, 32'd0);
    chk("rst_rd0_data", {26'd0, rd0_data}, 32'd0);
    chk("rst_rd1_data", {26'd0, rd1_data}, 32'd0);
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
  endtask

  // One cycle: drive at negedge, check grant, predict, then check registered outputs
  task automatic step(input vec_t v);
    logic g0, g1, sw, e0, e1;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    rd_exp_t r;
    g0 = v.g0;
    g1 = v.g1;
`ifdef MEM_ARB_FIXED_PRIO_EN
    g0 = v.v0;
    g1 = v.v1 & ~v.v0;
`endif
    req0_valid = v.v0; req0_write = v.w0; req0_addr = v.a0; req0_data = v.d0;
    req1_valid = v.v1; req1_write = v.w1; req1_addr = v.a1; req1_data = v.d1;
    #1;
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
    sw = g1 ? v.w1 : v.w0;
    sa = g1 ? v.a1 : v.a0;
    sd = g1 ? v.d1 : v.d0;
    exp_mw = (g0 | g1) & sw;
    exp_mr = (g0 | g1) & ~sw;
    if (g0 | g1) exp_addr = sa;
    if ((g0 | g1) && sw) begin
      exp_dout   = sd;
      shadow[sa] = sd;
    end
    if ((g0 | g1) && !sw) begin
      r.tag  = g1;
      r.data = shadow[sa];
      r.due  = cyc + LAT + 2;
      rdq.push_back(r);
    end
    @(negedge clk);
    cyc++;
    chk("mem_write", {31'd0, mem_write}, {31'd0, exp_mw});
    chk("mem_read", {31'd0, mem_read}, {31'd0, exp_mr});
    chk("mem_address", {29'd0, mem_address}, {29'd0, exp_addr});
    chk("mem_data_out", {26'd0, mem_data_out}, {26'd0, exp_dout});
    e0 = 1'b0;
    e1 = 1'b0;
    if (rdq.size() != 0 && rdq[0].due == cyc) begin
      r = rdq.pop_front();
      if (r.tag) begin
        e1 = 1'b1;
        exp_rd1 = r.data;
      end else begin
        e0 = 1'b1;
        exp_rd0 = r.data;
      end
    end
    chk("rd0_valid", {31'd0, rd0_valid}, {31'd0, e0});
    chk("rd1_valid", {31'd0, rd1_valid}, {31'd0, e1});
    chk("rd0_data", {26'd0, rd0_data}, {26'd0, exp_rd0});
    chk("rd1_data", {26'd0, rd1_data}, {26'd0, exp_rd1});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(mk(1'b0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0));
  endtask

  initial begin
    RESET_L = 1'b0;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 3'd0; req0_data = 6'd0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 3'd0; req1_data = 6'd0;
    exp_mw = 1'b0; exp_mr = 1'b0; exp_addr = 3'd0; exp_dout = 6'd0;
    exp_rd0 = 6'd0; exp_rd1 = 6'd0;
    for (int i = 0; i < 8; i++) shadow[i] = 6'd0;

    // Writes 0..7 by req0, reads 0..7 by req1, contention, mixed write/read
    for (int i = 0; i < 8; i++)
      vt.push_back(mk(1'b1, 1'b1, 3'(i), 6'(i + 1), 1'b0, 1'b0, 3'd0, 6'd0, 1'b1, 1'b0));
    for (int i = 0; i < 8; i++)
      vt.push_back(mk(1'b0, 1'b0, 3'd0, 6'd0, 1'b1, 1'b0, 3'(i), 6'd0, 1'b0, 1'b1));
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(1'b0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0));
    for (int i = 0; i < 6; i++)
      vt.push_back(mk(1'b1, 1'b0, 3'd3, 6'd0, 1'b1, 1'b0, 3'd4, 6'd0, (i % 2) == 0, (i % 2) == 1));
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(1'b0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 1'b1, 3'd5, 6'h2A, 1'b1, 1'b0, 3'd5, 6'd0, 1'b1, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 3'd0, 6'd0, 1'b1, 1'b0, 3'd5, 6'd0, 1'b0, 1'b1));
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(1'b0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0));

    repeat (2) @(negedge clk);
    chk_all_zero();
    RESET_L = 1'b1;

    for (int i = 0; i < vt.size(); i++) step(vt[i]);

    // Write 0xB to addr 0 by req0, then req1 reads it back on the next grant
    step(mk(1'b1, 1'b1, 3'd0, 6'h0B, 1'b0, 1'b0, 3'd0, 6'd0, 1'b1, 1'b0));
    step(mk(1'b0, 1'b0, 3'd0, 6'd0, 1'b1, 1'b0, 3'd0, 6'd0, 1'b0, 1'b1));
    idle(4);

    // Reset one cycle after a read accept: read is dropped, pointer returns to req0
    step(mk(1'b1, 1'b0, 3'd1, 6'd0, 1'b0, 1'b0, 3'd0, 6'd0, 1'b1, 1'b0));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    RESET_L = 1'b0;
    #1;
    chk_all_zero();
    rdq.delete();
    exp_mw = 1'b0; exp_mr = 1'b0; exp_addr = 3'd0; exp_dout = 6'd0;
    exp_rd0 = 6'd0; exp_rd1 = 6'd0;
    repeat (2) @(negedge clk);
    cyc += 2;
    RESET_L = 1'b1;
    idle(5);
    step(mk(1'b1, 1'b0, 3'd3, 6'd0, 1'b1, 1'b0, 3'd4, 6'd0, 1'b1, 1'b0));
    step(mk(1'b0, 1'b0, 3'd0, 6'd0, 1'b1, 1'b0, 3'd4, 6'd0, 1'b0, 1'b1));
    idle(4);

    chk("rdq_drained", rdq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 8x6 single-port register memory (write/read/address/data interface).
- Accepts independent valid/ready requests from requester 0 and 1, issues at most one memory command per cycle, and steers read data back to the originator.
- Default arbitration is round-robin; all memory-side outputs are registered.

Parameters:
- DATA_W, 6, memory word width
- ADDR_W, 3, memory address width (depth 2**ADDR_W = 8)
- MEM_RD_LAT, 1, cycles from mem_read sampled high to mem_data_in valid; range 1..4

Ports:
- clk  in  1  single clock, all logic on posedge
- RESET_L  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 command valid
- req0_write  in  1  1=write, 0=read
- req0_addr  in  ADDR_W  requester 0 address
- req0_data  in  DATA_W  requester 0 write data
- req0_ready  out  1  requester 0 command accepted this cycle (combinational grant)
- rd0_valid  out  1  read data for requester 0 valid
- rd0_data  out  DATA_W  read data for requester 0
- req1_valid, req1_write, req1_addr, req1_data, req1_ready, rd1_valid, rd1_data: same as requester 0, for requester 1
- mem_write  out  1  memory write strobe
- mem_read  out  1  memory read strobe
- mem_address  out  ADDR_W  memory address
- mem_data_out  out  DATA_W  memory write data
- mem_data_in  in  DATA_W  memory read data

Behaviour:
- Reset (RESET_L low, async): all outputs 0, priority pointer = requester 0, read-tag pipeline cleared. In-flight reads are dropped; no rdX_valid after reset release for commands issued before reset.
- Transfer occurs when reqX_valid && reqX_ready. Requesters hold valid/write/addr/data stable until ready.
- Grant: only one valid request -> grant it. Both valid -> grant the requester named by the pointer. After any grant, pointer := the non-granted requester. No grant -> pointer unchanged.
- reqX_ready is combinational from the valids and the pointer. It never depends on ready of the other side; no backpressure from memory.
- Issue: a transfer at edge k drives mem_address/mem_write or mem_read (and mem_data_out for writes) during cycle k..k+1, registered at edge k.
- Strobe rules:
  - mem_write and mem_read are never high together.
  - Both strobes deassert the cycle after a grant if no new grant occurs.
  - mem_address and mem_data_out hold their last value when idle.
- Read return:
  - A 1-bit requester tag plus a valid bit enter a MEM_RD_LAT-deep shift pipeline with mem_read.
  - When the tag exits, mem_data_in is registered into rdX_data and rdX_valid pulses for one cycle.
  - Read issued at edge k -> rdX_valid high during cycle after edge k+MEM_RD_LAT+1.
  - rdY_data is unchanged for the other requester.
- Throughput: one command per cycle sustained; back-to-back reads from alternating requesters return in issue order.
- Write-then-read to the same address on consecutive grants returns the new data; ordering is preserved by single issue.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN: when defined, requester 0 always wins simultaneous requests and the pointer register is removed. Requester 1 can starve.
- When undefined: round-robin as above.

Decomposition:
- Shared package mem_arb_pkg holds:
  - DATA_W/ADDR_W defaults
  - requester-id constants REQ0=0, REQ1=1
  - MEM_RD_LAT bounds
- Sub-module mem_arb_rr_pick: combinational two-way grant from valids and pointer.
- Pointer update, tag pipeline and output registers stay in the top module.

Test Plan:
- Write only, requester 0: writes addr 0..7 with data 1..8 on consecutive cycles -> req0_ready high every cycle; mem_write high 8 cycles with matching address/data, one cycle later.
- Read return, requester 1: reads addr 0..7 after the above -> rd1_valid pulses 8 consecutive cycles with data 1..8, first at MEM_RD_LAT+2 cycles after first accept; rd0_valid stays 0.
- Contention: both valid continuously, req0 read addr 3, req1 read addr 4 -> grants alternate 0,1,0,1 starting with req0 after reset; rd0_data=4, rd1_data=5 alternating. With MEM_ARB_FIXED_PRIO_EN, only req0 is granted.
- Write-then-read, same address: req0 writes 0xB to addr 0, then req1 reads addr 0 next cycle -> rd1_data=0xB.
- Reset mid-read: assert RESET_L low one cycle after a read accept -> all outputs 0 immediately; no rdX_valid after release; pointer back to requester 0.
- Idle: no valids for 5 cycles -> mem_read/mem_write 0, rdX_valid 0, mem_address holds last value.
